// File: rtl/bcd_pkg.sv
// ============================================================================
// bcd_pkg : shared BCD digit type, digit limit and subtractor FSM states
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      NEG  = 2'd2,
      DONE = 2'd3
   } sub_state_t;

   function automatic logic bcd_invalid(input bcd_t v);
      return (v > BCD_MAX);
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_sub.sv
// ============================================================================
// bcd_digit_sub : combinational one-digit BCD subtract cell, d = x - y - bin
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module bcd_digit_sub
   import bcd_pkg::*;
(
   input  bcd_t x,
   input  bcd_t y,
   input  logic bin,
   output bcd_t d,
   output logic bout
);

   logic [4:0] t;

   // Five bits hold x - y - bin over -16..15, so bit 4 is the sign.
   always_comb begin
      t = {1'b0, x} - {1'b0, y} - {4'b0000, bin};
      if (t[4]) begin
         d    = t[3:0] + 4'd10;
         bout = 1'b1;
      end else begin
         d    = t[3:0];
         bout = 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: rtl/bcd_serial_subtractor.sv
// ============================================================================
// bcd_serial_subtractor : digit-serial BCD a - b - bin, sign + magnitude out
// Rev 1.0 : initial release; optional digit check via BCD_SUB_CHECK_EN
// ============================================================================
`default_nettype none

module bcd_serial_subtractor
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  bin,
   output logic                  out_valid,
   input  logic                  out_ready,
`ifdef BCD_SUB_CHECK_EN
   output logic                  err,
`endif
   output logic [4*DIGITS-1:0]   diff,
   output logic                  neg
);

   localparam int              IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   sub_state_t          state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                borrow_q, borrow_d;
   logic [4*DIGITS-1:0] a_q, a_d;
   logic [4*DIGITS-1:0] b_q, b_d;
   logic [4*DIGITS-1:0] diff_q, diff_d;
   logic                neg_q, neg_d;

   bcd_t cell_x, cell_y, cell_d;
   logic cell_bout;

`ifdef BCD_SUB_CHECK_EN
   logic err_q, err_d;
   logic in_bad;

   always_comb begin
      in_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_invalid(a[4*i +: 4]) || bcd_invalid(b[4*i +: 4])) begin
            in_bad = 1'b1;
         end
      end
   end
`endif

   // The single cell serves both passes; NEG computes 0 - d_i - borrow.
   always_comb begin
      if (state_q == NEG) begin
         cell_x = 4'd0;
         cell_y = diff_q[4*int'(idx_q) +: 4];
      end else begin
         cell_x = a_q[4*int'(idx_q) +: 4];
         cell_y = b_q[4*int'(idx_q) +: 4];
      end
   end

   bcd_digit_sub u_cell (
      .x    (cell_x),
      .y    (cell_y),
      .bin  (borrow_q),
      .d    (cell_d),
      .bout (cell_bout)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      borrow_d = borrow_q;
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      neg_d    = neg_q;
`ifdef BCD_SUB_CHECK_EN
      err_d    = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d      = a;
               b_d      = b;
               borrow_d = bin;
               idx_d    = '0;
               diff_d   = '0;
               neg_d    = 1'b0;
               state_d  = SUB;
`ifdef BCD_SUB_CHECK_EN
               err_d    = in_bad;
`endif
            end
         end
         SUB: begin
            diff_d[4*int'(idx_q) +: 4] = cell_d;
            borrow_d = cell_bout;
            idx_d    = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               idx_d    = '0;
               borrow_d = 1'b0;
`ifdef BCD_SUB_CHECK_EN
               if (err_q) begin
                  diff_d  = '0;
                  neg_d   = 1'b0;
                  state_d = DONE;
               end else
`endif
               if (cell_bout) begin
                  neg_d   = 1'b1;
                  state_d = NEG;
               end else begin
                  neg_d   = 1'b0;
                  state_d = DONE;
               end
            end
         end
         NEG: begin
            diff_d[4*int'(idx_q) +: 4] = cell_d;
            borrow_d = cell_bout;
            idx_d    = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               idx_d    = '0;
               borrow_d = 1'b0;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
`ifdef BCD_SUB_CHECK_EN
               err_d   = 1'b0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         borrow_q <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         neg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         borrow_q <= borrow_d;
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         neg_q    <= neg_d;
      end
   end

`ifdef BCD_SUB_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q & (state_q == DONE);
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign diff      = diff_q;
   assign neg       = neg_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_subtractor.sv
// ============================================================================
// tb_bcd_serial_subtractor : directed self-checking bench for the subtractor
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_bcd_serial_subtractor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        bin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] diff;
   logic        neg;
`ifdef BCD_SUB_CHECK_EN
   logic        err;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bcd_serial_subtractor #(.DIGITS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef BCD_SUB_CHECK_EN
      .err       (err),
`endif
      .diff      (diff),
      .neg       (neg)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accept one operation, measure latency to out_valid, check result, handshake.
   task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                         input logic ibin, input logic [15:0] ed, input logic en,
                         input int elat, input logic eerr);
      int cnt;
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      a = ia; b = ib; bin = ibin; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk({tag, "_latency"}, cnt, elat);
      chk({tag, "_diff"}, {16'd0, diff}, {16'd0, ed});
      chk({tag, "_neg"}, {31'd0, neg}, {31'd0, en});
`ifdef BCD_SUB_CHECK_EN
      chk({tag, "_err"}, {31'd0, err}, {31'd0, eerr});
`else
      if (eerr) chk({tag, "_err_unsupported"}, 32'd0, 32'd1);
`endif
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_diff", {16'd0, diff}, 32'd0);
      chk("rst_neg", {31'd0, neg}, 32'd0);

      run_op("pos",   16'h1234, 16'h0567, 1'b0, 16'h0667, 1'b0, 4, 1'b0);
      run_op("negr",  16'h0567, 16'h1234, 1'b0, 16'h0667, 1'b1, 8, 1'b0);
      run_op("zb",    16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b1, 8, 1'b0);
      run_op("nines", 16'h9999, 16'h9999, 1'b1, 16'h0001, 1'b1, 8, 1'b0);
      run_op("max",   16'h9999, 16'h0000, 1'b0, 16'h9999, 1'b0, 4, 1'b0);
      run_op("brw",   16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0, 4, 1'b0);
      run_op("equal", 16'h4321, 16'h4321, 1'b0, 16'h0000, 1'b0, 4, 1'b0);

      // Backpressure: result held while new operands are offered.
      a = 16'h1234; b = 16'h0567; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 16'h8888; b = 16'h1111; bin = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      chk("bp_valid0", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("bp_diff", {16'd0, diff}, 32'h0667);
         chk("bp_neg", {31'd0, neg}, 32'd0);
         chk("bp_ready_valid", {30'd0, in_ready, out_valid}, 32'd1);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release", {30'd0, in_ready, out_valid}, 32'd2);
      @(posedge clk); #1;
      chk("bp_no_accept", {31'd0, in_ready}, 32'd1);

      // Reset during the second SUB cycle.
      a = 16'h1234; b = 16'h0567; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("mid_busy", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_state", {13'd0, out_valid, neg, in_ready, diff}, {13'd0, 3'b001, 16'h0000});
      run_op("after_rst", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 4, 1'b0);

`ifdef BCD_SUB_CHECK_EN
      run_op("chk_bad", 16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 4, 1'b1);
      run_op("chk_ok",  16'h1234, 16'h0567, 1'b0, 16'h0667, 1'b0, 4, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
